// File: rtl/instr_mem_loader.sv
// Boot-time programming controller: turns a length-prefixed little-endian byte stream
// into sequential 32-bit instruction-memory writes while holding the core in reset.
module instr_mem_loader #(
    parameter int MEM_SIZE_WORDS = 1024,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        prog_req_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_hold_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    localparam int IDXW = $clog2(MEM_SIZE_WORDS) + 1;
    localparam int CNTW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNTW-1:0] IDLE_LAST = CNTW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_LOAD, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t          r_state;
    logic [IDXW-1:0] r_len;
    logic [1:0]      r_byte_cnt;
    logic [23:0]     r_asm;
    logic [IDXW-1:0] r_word_idx;
    logic [CNTW-1:0] r_idle_cnt;
    logic            r_mem_we;
    logic [31:0]     r_mem_addr;
    logic [31:0]     r_mem_wdata;
    logic            r_hold;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic [31:0]     w_word;
    logic [IDXW-1:0] w_idx_next;
    logic            w_last_word;
    logic            w_timeout;

    // The same three-byte assembler serves both the length header and payload words.
    assign w_word      = {rx_data_i, r_asm};
    assign w_idx_next  = r_word_idx + IDXW'(1);
    assign w_last_word = (w_idx_next == r_len);
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_idle_cnt == IDLE_LAST);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_byte_cnt  <= '0;
            r_asm       <= '0;
            r_word_idx  <= '0;
            r_idle_cnt  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hold      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            if (prog_req_i) begin
                // A request always (re)opens a session; any byte this cycle is dropped.
                r_state    <= S_LEN;
                r_byte_cnt <= '0;
                r_word_idx <= '0;
                r_idle_cnt <= '0;
                r_err      <= 1'b0;
                r_hold     <= 1'b1;
                r_busy     <= 1'b1;
            end else begin
                case (r_state)
                    S_LEN, S_LOAD: begin
                        if (rx_valid_i) begin
                            r_idle_cnt <= '0;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            case (r_byte_cnt)
                                2'd0:    r_asm[7:0]   <= rx_data_i;
                                2'd1:    r_asm[15:8]  <= rx_data_i;
                                2'd2:    r_asm[23:16] <= rx_data_i;
                                default: ;
                            endcase
                            if (r_byte_cnt == 2'd3) begin
                                if (r_state == S_LEN) begin
                                    r_len <= w_word[IDXW-1:0];
                                    if (w_word == '0) begin
                                        r_state <= S_DONE;
                                        r_done  <= 1'b1;
                                    end else if (w_word > MEM_WORDS) begin
                                        r_state <= S_ERR;
                                        r_err   <= 1'b1;
                                        r_busy  <= 1'b0;
                                    end else begin
                                        r_state <= S_LOAD;
                                    end
                                end else begin
                                    r_state     <= S_WRITE;
                                    r_mem_we    <= 1'b1;
                                    r_mem_wdata <= w_word;
                                    r_mem_addr  <= 32'({r_word_idx, 2'b00});
                                end
                            end
                        end else if (w_timeout) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (TIMEOUT_CYCLES != 0) begin
                            r_idle_cnt <= r_idle_cnt + CNTW'(1);
                        end
                    end
                    S_WRITE: begin
                        r_word_idx <= w_idx_next;
                        // A byte landing here is the first byte of the following word.
                        if (rx_valid_i) begin
                            r_asm[7:0] <= rx_data_i;
                            r_byte_cnt <= 2'd1;
                            r_idle_cnt <= '0;
                        end
                        if (w_last_word) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_hold  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                    S_IDLE, S_ERR: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign core_hold_o = r_hold;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Programming controller that fills the instruction memory from a byte stream, normally the UART receiver.
- Parses a 4-byte little-endian word-count header, then assembles payload bytes into 32-bit little-endian words.
- Issues one sequential write per word to the instruction memory's write port.
- Holds the core in reset for the whole session, so the core only fetches once the image is complete.

Parameters:
- MEM_SIZE_WORDS, 1024, instruction memory depth in words; header counts above this are rejected.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a session; 0 disables the timeout.

Ports:
- clk_i  input  1  system clock
- arstn_i  input  1  asynchronous active-low reset
- prog_req_i  input  1  single-cycle start (or restart) of a programming session
- rx_valid_i  input  1  rx_data_i holds a valid byte this cycle
- rx_data_i  input  8  received byte
- mem_we_o  output  1  instruction memory write enable, one cycle per word
- mem_addr_o  output  32  byte address of the write, always word-aligned
- mem_wdata_o  output  32  write data
- core_hold_o  output  1  keeps the core in reset while high
- busy_o  output  1  a session is in progress
- done_o  output  1  one-cycle pulse when the image has loaded successfully
- err_o  output  1  sticky error flag (bad length or timeout)

Behaviour:
- Clock/reset:
  - One clock; reset is asynchronous and active-low (arstn_i), the polarity and synchronicity are fixed.
  - Reset takes effect immediately: state IDLE, all outputs 0, all counters and assembly registers cleared.
  - Reset mid-session abandons the session; already-written words stay in memory.
- FSM states: IDLE, LEN, LOAD, WRITE, DONE, ERR.
- IDLE:
  - core_hold_o=0, busy_o=0. Bytes are ignored.
  - prog_req_i -> LEN; clear byte counter, word index and err_o.
- LEN:
  - Accept 4 bytes; byte k (0..3) goes to bits [8k+7:8k] of N.
  - After the 4th byte: N=0 -> DONE; N>MEM_SIZE_WORDS -> ERR; otherwise -> LOAD.
- LOAD:
  - Accept bytes into the word assembler, same little-endian rule as LEN.
  - On the 4th byte, latch mem_wdata_o, set mem_addr_o = word_idx*4 and go to WRITE.
- WRITE (exactly one cycle):
  - mem_we_o=1.
  - word_idx increments at the end of the cycle.
  - If word_idx+1 == N -> DONE, else -> LOAD.
  - A byte arriving during WRITE is accepted as byte 0 of the next word and is not dropped.
- DONE (one cycle):
  - done_o=1, core_hold_o=1. Bytes are ignored.
  - Next state IDLE, where hold is released.
- ERR:
  - err_o=1, core_hold_o=1, busy_o=0. Bytes are ignored.
  - Stays in ERR until prog_req_i, then -> LEN with err_o cleared.
- Outputs and latency:
  - core_hold_o=1 and busy_o=1 in LEN, LOAD, WRITE and DONE.
  - mem_we_o is high only in WRITE.
  - mem_addr_o and mem_wdata_o hold their last values outside WRITE.
  - Write latency: 4th byte of a word sampled at edge t -> mem_we_o high in cycle t+1.
  - After the last write: done_o in the next cycle, then core_hold_o low the cycle after that.
- Timeout:
  - Idle counter is cleared on every accepted byte and on entering LEN.
  - It increments in LEN and LOAD when rx_valid_i=0.
  - Counter reaching TIMEOUT_CYCLES -> ERR. WRITE does not count.
- Simultaneous events:
  - prog_req_i in any state other than IDLE or ERR restarts the session at LEN: counters cleared, hold stays high.
  - prog_req_i and rx_valid_i in the same cycle: the restart wins and the byte is discarded.
- Arithmetic:
  - word_idx is $clog2(MEM_SIZE_WORDS)+1 bits wide, so it cannot wrap before N.
  - mem_addr_o = {zero-extend(word_idx), 2'b00}.

Test Plan:
- Basic load:
  - prog_req, header 02 00 00 00, payload 13 00 00 00 EF BE AD DE.
  - Expect two mem_we_o pulses: addr 0x0 data 0x00000013, then addr 0x4 data 0xDEADBEEF.
  - done_o one cycle after the second write; core_hold_o falls one cycle later.
- Zero length:
  - Header 00 00 00 00.
  - No write; done_o in the cycle after the 4th header byte; err_o=0.
- Oversize:
  - Header with N=MEM_SIZE_WORDS+1 (0x401).
  - ERR, err_o=1, core_hold_o=1, no writes.
  - A new prog_req clears err_o and a valid load then succeeds.
- Timeout (TIMEOUT_CYCLES=16):
  - Stop after 2 payload bytes.
  - err_o rises after 16 idle cycles; later bytes are ignored.
- Restart and back-to-back:
  - prog_req_i mid-LOAD together with a byte: byte discarded, next 4 bytes treated as a header.
  - Bytes arriving in consecutive cycles, including during WRITE, all land in the correct words.
- Reset:
  - arstn_i low mid-LOAD drops all outputs immediately, including core_hold_o.
  - After release the block sits in IDLE and ignores bytes until prog_req_i.
